stmm_writeback: RTL and testbench
=================================

# stmm_writeback

Output drain for the StMM execution unit. Captures each sub-unit's 176-byte result row when that sub-unit's `exec_done` pulses, buffers one row per sub-unit, and streams buffered rows to SDRAM as 128-bit write beats under round-robin arbitration. It sits directly downstream of the StMM wrapper, consuming `Y_out`/`exec_done`, and upstream of the SDRAM write port.

## Interface
- `SUB_NUM`, 4, number of StMM sub-units / buffer slots
- `N`, 176, output row length in bytes
- `SDRAM_W`, 128, SDRAM data width in bits; `N*8` must be a multiple of `SDRAM_W` (elaboration-time check)
- `ADDR_W`, 24, SDRAM word-address width

Ports:
- `clk`  in  1  clock; everything is on the rising edge
- `rst`  in  1  reset, synchronous and active-high
- `exec_done`  in  SUB_NUM  per-sub result-valid pulse
- `y_data`  in  SUB_NUM × N*8  per-sub result row; byte 0 is in bits [7:0]
- `cfg_we`  in  1  base-address write strobe
- `cfg_sub_idx`  in  2  base-address target slot
- `cfg_base`  in  ADDR_W  base word address for that slot
- `wr_valid`  out  1  write beat valid
- `wr_ready`  in  1  SDRAM accepts the beat
- `wr_addr`  out  ADDR_W  beat word address
- `wr_data`  out  SDRAM_W  beat data
- `wb_done`  out  SUB_NUM  one-cycle pulse when a slot's last beat is accepted
- `overflow`  out  SUB_NUM  sticky flag: a capture was dropped because the slot was full
- `busy`  out  1  any slot full or FSM in SEND

## Operation
- BEATS = N*8/SDRAM_W, which is 11 at the default parameters. Beat k carries `y_data[sel][SDRAM_W*k +: SDRAM_W]` and `wr_addr = slot_base[sel] + k` (modulo 2^ADDR_W).
- `base_reg[s]` is written by `cfg_we` at any time.
- On capture, the slot snapshots both the row and `base_reg[s]`. A later cfg write does not affect a row that is already buffered.
- Slot capture:
  - `exec_done[s]` with slot s empty: the slot stores the row and the base, and becomes full.
  - `exec_done[s]` with slot s full: the capture is dropped, the old data is kept, and `overflow[s]` is set.
  - Exception: if slot s's last beat is accepted in the same cycle, the capture is taken and the slot stays full with the new row. `overflow` is not set.
- FSM states are IDLE and SEND.
  - IDLE: if any slot is full, grant by round-robin, searching from `last_grant+1` upward with wrap-around. Latch `sel`, set `beat=0`, and go to SEND. Otherwise stay in IDLE.
  - SEND: `wr_valid=1`.
    - On `wr_ready` with `beat<BEATS-1`: `beat` increments.
    - On `wr_ready` with `beat==BEATS-1`: clear slot `sel` (unless a new capture coincides), pulse `wb_done[sel]`, set `last_grant=sel`, and go to IDLE.
- While `wr_valid && !wr_ready`, `wr_addr` and `wr_data` are held stable. `wr_valid` never drops mid-row.
- `overflow` is cleared only by `rst`.

## Timing
- Reset values:
  - FSM in IDLE, all slots empty, `beat=0`, `last_grant=SUB_NUM-1`, `base_reg=0`.
  - `wr_valid=0`, `wr_addr=0`, `wr_data=0`, `wb_done=0`, `overflow=0`, `busy=0`.
- `rst` asserted mid-row: the row is abandoned with no `wb_done`, and `wr_valid` is 0 in the cycle after reset.
- Latency: `exec_done` at cycle t gives slot full at t+1 and IDLE grant at t+1, so the first `wr_valid` is at t+2.
- With `wr_ready` held high, one row takes BEATS cycles. `wb_done` pulses in the cycle after the last beat is accepted, i.e. with the registered state.
- Between rows there is exactly one IDLE cycle (`wr_valid=0`).
- `wr_data`/`wr_addr` are registered or derived from registered state only, with no combinational path from `wr_ready`.

## Structure
- Shared package `stmm_pkg` holds:
  - `SUB_NUM`, `N`, `SDRAM_W`
  - the derived `BEATS`
  - the FSM enum `wb_state_t {WB_IDLE, WB_SEND}`
- Sub-module `rr_arbiter #(REQ_N)`: a combinational round-robin grant from a request vector and `last_grant`. It is reusable by the fetch side.
- Slot storage is an array of N*8-bit registers. It must not be mapped to BRAM, because the capture is full-row in a single cycle.

## Test plan
- Single row:
  - Stimulus: `cfg_base[2]=0x100`; `exec_done[2]` with bytes 0..175 = 0..175; `wr_ready=1`.
  - Response: 11 beats at addresses 0x100..0x10A; beat 0 = bytes 0..15; `wb_done[2]` one pulse; `busy` falls.
- Backpressure:
  - Stimulus: same row as above, with `wr_ready` toggling 1/0 every cycle.
  - Response: data and address held while not ready; exactly 11 accepted beats; 22 SEND cycles.
- Round-robin:
  - Stimulus: `exec_done` = 4'b1111 in one cycle, with `last_grant` at its reset value.
  - Response: rows drain in order 0,1,2,3 with one IDLE cycle between rows. Then refill slots 0 and 3: order 0,3.
- Overflow:
  - Stimulus: `exec_done[1]` twice while slot 1 is waiting behind slot 0.
  - Response: `overflow[1]=1`; the first row's data is written; the second row is dropped.
- Capture on last beat:
  - Stimulus: `exec_done[0]` in the same cycle as slot 0's last-beat accept.
  - Response: no overflow; the new row is written next with its new snapshot base.
- Reset mid-row:
  - Stimulus: assert `rst` at beat 5.
  - Response: next cycle `wr_valid=0`, all outputs at reset values, no `wb_done`.

Source files
------------

// File: rtl/stmm_writeback_pkg.sv
// Shared constants and FSM encoding for the StMM execution unit.
// Imported by the writeback drain and by the fetch side.
package stmm_pkg;

    localparam int SUB_NUM = 4;
    localparam int N       = 176;
    localparam int SDRAM_W = 128;
    localparam int ADDR_W  = 24;
    localparam int BEATS   = (N * 8) / SDRAM_W;

    typedef enum logic [0:0] {
        WB_IDLE = 1'b0,
        WB_SEND = 1'b1
    } wb_state_t;

endpackage

// File: rtl/stmm_writeback_if.sv
// SDRAM write-beat port: valid/ready handshake carrying one word address and one data beat.
// master drives beats, slave returns ready.
interface stmm_wr_if #(
    parameter int ADDR_W = 24,
    parameter int DATA_W = 128
);
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    modport master (
        output wr_valid,
        output wr_addr,
        output wr_data,
        input  wr_ready
    );

    modport slave (
        input  wr_valid,
        input  wr_addr,
        input  wr_data,
        output wr_ready
    );
endinterface

// File: rtl/stmm_writeback_rr_arbiter.sv
// Combinational round-robin grant: searches upward from last_grant+1 with wrap-around.
// Zero latency; no backpressure, the caller decides when to consume the grant.
module rr_arbiter #(
    parameter  int REQ_N = 4,
    localparam int IDX_W = (REQ_N > 1) ? $clog2(REQ_N) : 1
) (
    input  logic [REQ_N-1:0] req,
    input  logic [IDX_W-1:0] last_grant,
    output logic             gnt_vld,
    output logic [IDX_W-1:0] gnt_idx
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int i = 1; i <= REQ_N; i++) begin
            cand = IDX_W'((int'(last_grant) + i) % REQ_N);
            if (!gnt_vld && req[cand]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand;
            end
        end
    end

endmodule

// File: rtl/stmm_writeback.sv
// Buffers one result row per sub-unit and drains rows to SDRAM as write beats, round-robin.
// exec_done -> first wr_valid in 2 cycles; beats hold stable while wr_ready is low.
module stmm_writeback
    import stmm_pkg::*;
#(
    parameter  int SUB_NUM = stmm_pkg::SUB_NUM,
    parameter  int N       = stmm_pkg::N,
    parameter  int SDRAM_W = stmm_pkg::SDRAM_W,
    parameter  int ADDR_W  = stmm_pkg::ADDR_W,
    localparam int IDX_W   = (SUB_NUM > 1) ? $clog2(SUB_NUM) : 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [SUB_NUM-1:0]              exec_done,
    input  logic [SUB_NUM-1:0][N*8-1:0]     y_data,
    input  logic                            cfg_we,
    input  logic [IDX_W-1:0]                cfg_sub_idx,
    input  logic [ADDR_W-1:0]               cfg_base,
    stmm_wr_if.master                       wr,
    output logic [SUB_NUM-1:0]              wb_done,
    output logic [SUB_NUM-1:0]              overflow,
    output logic                            busy
);

    localparam int NBEATS = (N * 8) / SDRAM_W;
    localparam int BEAT_W = (NBEATS > 1) ? $clog2(NBEATS) : 1;

    if (((N * 8) % SDRAM_W) != 0) begin : g_width_chk
        $error("stmm_writeback: row width N*8 must be a multiple of SDRAM_W");
    end

    wb_state_t                         state, state_nxt;
    logic [IDX_W-1:0]                  sel, sel_nxt;
    logic [IDX_W-1:0]                  last_grant, last_grant_nxt;
    logic [BEAT_W-1:0]                 beat, beat_nxt;

    // Row storage is flop-based: a whole row lands in one cycle, so it cannot live in block RAM.
    logic [NBEATS-1:0][SDRAM_W-1:0]    slot_row  [SUB_NUM];
    logic [ADDR_W-1:0]                 slot_base [SUB_NUM];
    logic [ADDR_W-1:0]                 base_reg  [SUB_NUM];
    logic [SUB_NUM-1:0]                slot_full;

    logic                              gnt_vld;
    logic [IDX_W-1:0]                  gnt_idx;
    logic                              sending;
    logic                              last_acc;
    logic [SUB_NUM-1:0]                done_vec;
    logic [SUB_NUM-1:0]                cap_take;

    assign sending  = (state == WB_SEND);
    assign last_acc = sending && wr.wr_ready && (beat == BEAT_W'(NBEATS - 1));

    always_comb begin
        done_vec = '0;
        if (last_acc) begin
            done_vec[sel] = 1'b1;
        end
    end

    // A capture is accepted into an empty slot, or into the slot whose last beat leaves this cycle.
    assign cap_take = exec_done & (~slot_full | done_vec);

    rr_arbiter #(
        .REQ_N      (SUB_NUM)
    ) u_arb (
        .req        (slot_full),
        .last_grant (last_grant),
        .gnt_vld    (gnt_vld),
        .gnt_idx    (gnt_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SUB_NUM; s++) begin
                base_reg[s] <= '0;
            end
        end else if (cfg_we) begin
            base_reg[cfg_sub_idx] <= cfg_base;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_full <= '0;
            overflow  <= '0;
        end else begin
            for (int s = 0; s < SUB_NUM; s++) begin
                if (exec_done[s]) begin
                    if (cap_take[s]) begin
                        slot_full[s] <= 1'b1;
                    end else begin
                        overflow[s]  <= 1'b1;
                    end
                end else if (done_vec[s]) begin
                    slot_full[s] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int s = 0; s < SUB_NUM; s++) begin
            if (cap_take[s]) begin
                slot_row[s]  <= y_data[s];
                slot_base[s] <= base_reg[s];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= WB_IDLE;
            sel        <= '0;
            beat       <= '0;
            last_grant <= IDX_W'(SUB_NUM - 1);
            wb_done    <= '0;
        end else begin
            state      <= state_nxt;
            sel        <= sel_nxt;
            beat       <= beat_nxt;
            last_grant <= last_grant_nxt;
            wb_done    <= done_vec;
        end
    end

    always_comb begin
        state_nxt      = state;
        sel_nxt        = sel;
        beat_nxt       = beat;
        last_grant_nxt = last_grant;
        case (state)
            WB_IDLE: begin
                if (gnt_vld) begin
                    sel_nxt   = gnt_idx;
                    beat_nxt  = '0;
                    state_nxt = WB_SEND;
                end
            end
            WB_SEND: begin
                if (last_acc) begin
                    beat_nxt       = '0;
                    last_grant_nxt = sel;
                    state_nxt      = WB_IDLE;
                end else if (wr.wr_ready) begin
                    beat_nxt = beat + BEAT_W'(1);
                end
            end
            default: begin
                state_nxt = WB_IDLE;
            end
        endcase
    end

    // Beat address/data come only from registered state, so they cannot glitch with wr_ready.
    assign wr.wr_valid = sending;
    assign wr.wr_addr  = sending ? (slot_base[sel] + ADDR_W'(beat)) : '0;
    assign wr.wr_data  = sending ? slot_row[sel][beat] : '0;
    assign busy        = (|slot_full) || sending;

endmodule

// File: tb/tb_stmm_writeback.sv
// Directed bench for stmm_writeback: capture, drain, arbitration, overflow and reset cases.
module tb_stmm_writeback;
    import stmm_pkg::*;

    localparam int AW = 24;
    localparam int DW = 128;
    localparam int NB = 11;
    localparam int RW = 1408;

    logic               clk = 1'b0;
    logic               rst;
    logic [3:0]         exec_done;
    logic [3:0][RW-1:0] y_data;
    logic               cfg_we;
    logic [1:0]         cfg_sub_idx;
    logic [AW-1:0]      cfg_base;
    logic [3:0]         wb_done;
    logic [3:0]         overflow;
    logic               busy;

    always #5 clk = ~clk;

    stmm_wr_if #(.ADDR_W(AW), .DATA_W(DW)) wr ();

    stmm_writeback #(
        .SUB_NUM     (4),
        .N           (176),
        .SDRAM_W     (128),
        .ADDR_W      (24)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .exec_done   (exec_done),
        .y_data      (y_data),
        .cfg_we      (cfg_we),
        .cfg_sub_idx (cfg_sub_idx),
        .cfg_base    (cfg_base),
        .wr          (wr),
        .wb_done     (wb_done),
        .overflow    (overflow),
        .busy        (busy)
    );

    int            checks = 0;
    int            errors = 0;
    logic [AW-1:0] cap_addr [NB];
    logic [DW-1:0] cap_data [NB];
    int            cap_n, send_cyc, hold_bad, gap, wb_cnt;
    logic [3:0]    wb_end;
    bit            drain_to;

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic [RW-1:0] mk_row(input int seed);
        logic [RW-1:0] r;
        r = '0;
        for (int i = 0; i < 176; i++) r[8*i +: 8] = 8'((seed + i) & 255);
        return r;
    endfunction

    task automatic cfg_write(input int s, input logic [AW-1:0] b);
        cfg_we = 1'b1; cfg_sub_idx = 2'(s); cfg_base = b;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic pulse(input logic [3:0] m);
        exec_done = m;
        tick();
        exec_done = '0;
    endtask

    // Records one row of accepted beats; optionally fires exec_done together with the last accept.
    task automatic drain(input bit toggle, input logic [3:0] inj, input int budget);
        int t, k;
        logic pv_nr;
        logic [AW-1:0] pa;
        logic [DW-1:0] pd;
        t = 0; k = 0; pv_nr = 1'b0; pa = '0; pd = '0;
        cap_n = 0; send_cyc = 0; hold_bad = 0; wb_cnt = 0; drain_to = 1'b0; wb_end = '0;
        wr.wr_ready = 1'b0;
        while (!wr.wr_valid && t < budget) begin tick(); t++; end
        gap = t;
        if (!wr.wr_valid) begin drain_to = 1'b1; return; end
        while (wr.wr_valid && t < budget) begin
            send_cyc++;
            if (wb_done != 0) wb_cnt++;
            if (pv_nr && (wr.wr_addr !== pa || wr.wr_data !== pd)) hold_bad++;
            wr.wr_ready = toggle ? k[0] : 1'b1;
            k++;
            if (wr.wr_ready) begin
                if (cap_n < NB) begin
                    cap_addr[cap_n] = wr.wr_addr;
                    cap_data[cap_n] = wr.wr_data;
                end
                if (cap_n == NB - 1) exec_done = inj;
                cap_n++;
            end
            pv_nr = !wr.wr_ready; pa = wr.wr_addr; pd = wr.wr_data;
            tick(); t++;
            exec_done = '0;
        end
        wr.wr_ready = 1'b0;
        if (wr.wr_valid) drain_to = 1'b1;
        wb_end = wb_done;
    endtask

    task automatic test_reset();
        rst = 1'b1; exec_done = '0; y_data = '0; cfg_we = 1'b0; cfg_sub_idx = '0; cfg_base = '0;
        wr.wr_ready = 1'b0;
        repeat (3) tick();
        checks++; if (wr.wr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", wr.wr_valid); end
        checks++; if (wr.wr_addr !== 24'h0) begin errors++; $display("FAIL reset_addr got %h exp 0", wr.wr_addr); end
        checks++; if (wr.wr_data !== 128'h0) begin errors++; $display("FAIL reset_data got %h exp 0", wr.wr_data); end
        checks++; if (wb_done !== 4'b0) begin errors++; $display("FAIL reset_wb_done got %b exp 0000", wb_done); end
        checks++; if (overflow !== 4'b0) begin errors++; $display("FAIL reset_overflow got %b exp 0000", overflow); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_row();
        logic [RW-1:0] row;
        int bad;
        row = mk_row(0);
        y_data[2] = row;
        cfg_write(2, 24'h100);
        pulse(4'b0100);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_rise got %b exp 1", busy); end
        checks++; if (wr.wr_valid !== 1'b0) begin errors++; $display("FAIL single_grant_cycle got %b exp 0", wr.wr_valid); end
        drain(1'b0, 4'b0, 100);
        checks++; if (drain_to !== 1'b0) begin errors++; $display("FAIL single_timeout got %b exp 0", drain_to); end
        checks++; if (gap !== 1) begin errors++; $display("FAIL single_latency got %0d exp 1", gap); end
        checks++; if (cap_n !== NB) begin errors++; $display("FAIL single_beats got %0d exp %0d", cap_n, NB); end
        checks++; if (cap_addr[0] !== 24'h100) begin errors++; $display("FAIL single_addr0 got %h exp 100", cap_addr[0]); end
        checks++; if (cap_addr[10] !== 24'h10A) begin errors++; $display("FAIL single_addr10 got %h exp 10a", cap_addr[10]); end
        checks++;
        if (cap_data[0] !== 128'h0f0e0d0c0b0a09080706050403020100) begin
            errors++; $display("FAIL single_data0 got %h exp 0f0e0d0c0b0a09080706050403020100", cap_data[0]);
        end
        checks++;
        if (cap_data[10] !== 128'hafaeadacabaaa9a8a7a6a5a4a3a2a1a0) begin
            errors++; $display("FAIL single_data10 got %h exp afaeadacabaaa9a8a7a6a5a4a3a2a1a0", cap_data[10]);
        end
        bad = 0;
        for (int k = 0; k < NB; k++) begin
            if (cap_addr[k] !== 24'(32'h100 + k) || cap_data[k] !== row[128*k +: 128]) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL single_all_beats got %0d bad exp 0", bad); end
        checks++; if (send_cyc !== NB) begin errors++; $display("FAIL single_send_cycles got %0d exp %0d", send_cyc, NB); end
        checks++; if (wb_end !== 4'b0100) begin errors++; $display("FAIL single_wb_done got %b exp 0100", wb_end); end
        checks++; if (wb_cnt !== 0) begin errors++; $display("FAIL single_wb_early got %0d exp 0", wb_cnt); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_fall got %b exp 0", busy); end
        tick();
        checks++; if (wb_done !== 4'b0) begin errors++; $display("FAIL single_wb_width got %b exp 0000", wb_done); end
    endtask

    task automatic test_backpressure();
        logic [RW-1:0] row;
        int bad;
        row = mk_row(0);
        pulse(4'b0100);
        drain(1'b1, 4'b0, 200);
        checks++; if (drain_to !== 1'b0) begin errors++; $display("FAIL bp_timeout got %b exp 0", drain_to); end
        checks++; if (cap_n !== NB) begin errors++; $display("FAIL bp_beats got %0d exp %0d", cap_n, NB); end
        checks++; if (send_cyc !== 22) begin errors++; $display("FAIL bp_send_cycles got %0d exp 22", send_cyc); end
        checks++; if (hold_bad !== 0) begin errors++; $display("FAIL bp_hold got %0d exp 0", hold_bad); end
        bad = 0;
        for (int k = 0; k < NB; k++) begin
            if (cap_addr[k] !== 24'(32'h100 + k) || cap_data[k] !== row[128*k +: 128]) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL bp_all_beats got %0d bad exp 0", bad); end
        checks++; if (wb_end !== 4'b0100) begin errors++; $display("FAIL bp_wb_done got %b exp 0100", wb_end); end
    endtask

    task automatic test_round_robin();
        logic [AW-1:0] bases [4];
        logic [RW-1:0] rows [4];
        int ord [2];
        int s;
        rst = 1'b1; tick(); rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bases[i] = 24'(32'h200 + 32 * i);
            rows[i]  = mk_row(16 * i + 1);
            y_data[i] = rows[i];
            cfg_write(i, bases[i]);
        end
        pulse(4'b1111);
        for (int r = 0; r < 4; r++) begin
            drain(1'b0, 4'b0, 100);
            checks++; if (cap_addr[0] !== bases[r]) begin errors++; $display("FAIL rr_order%0d_addr got %h exp %h", r, cap_addr[0], bases[r]); end
            checks++; if (cap_data[0] !== rows[r][127:0]) begin errors++; $display("FAIL rr_order%0d_data got %h exp %h", r, cap_data[0], rows[r][127:0]); end
            checks++; if (wb_end !== 4'(1 << r)) begin errors++; $display("FAIL rr_order%0d_wb got %b exp %b", r, wb_end, 4'(1 << r)); end
            checks++; if (gap !== 1) begin errors++; $display("FAIL rr_gap%0d got %0d exp 1", r, gap); end
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rr_busy got %b exp 0", busy); end
        ord[0] = 0; ord[1] = 3;
        pulse(4'b1001);
        for (int r = 0; r < 2; r++) begin
            s = ord[r];
            drain(1'b0, 4'b0, 100);
            checks++; if (cap_addr[0] !== bases[s]) begin errors++; $display("FAIL rr_refill%0d_addr got %h exp %h", r, cap_addr[0], bases[s]); end
            checks++; if (wb_end !== 4'(1 << s)) begin errors++; $display("FAIL rr_refill%0d_wb got %b exp %b", r, wb_end, 4'(1 << s)); end
        end
    endtask

    task automatic test_overflow();
        logic [RW-1:0] row_a, row_b;
        int bad;
        row_a = mk_row(100);
        row_b = mk_row(200);
        y_data[0] = mk_row(50);
        y_data[1] = row_a;
        pulse(4'b0011);
        y_data[1] = row_b;
        pulse(4'b0010);
        checks++; if (overflow !== 4'b0010) begin errors++; $display("FAIL ovf_flag got %b exp 0010", overflow); end
        drain(1'b0, 4'b0, 100);
        checks++; if (wb_end !== 4'b0001) begin errors++; $display("FAIL ovf_first_wb got %b exp 0001", wb_end); end
        drain(1'b0, 4'b0, 100);
        checks++; if (wb_end !== 4'b0010) begin errors++; $display("FAIL ovf_second_wb got %b exp 0010", wb_end); end
        checks++; if (cap_n !== NB) begin errors++; $display("FAIL ovf_beats got %0d exp %0d", cap_n, NB); end
        bad = 0;
        for (int k = 0; k < NB; k++) if (cap_data[k] !== row_a[128*k +: 128]) bad++;
        checks++; if (bad !== 0) begin errors++; $display("FAIL ovf_kept_row got %0d bad exp 0", bad); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ovf_dropped_busy got %b exp 0", busy); end
        tick();
        checks++; if (wr.wr_valid !== 1'b0) begin errors++; $display("FAIL ovf_no_extra_row got %b exp 0", wr.wr_valid); end
        checks++; if (overflow !== 4'b0010) begin errors++; $display("FAIL ovf_sticky got %b exp 0010", overflow); end
    endtask

    task automatic test_capture_last_beat();
        logic [RW-1:0] row_c, row_d;
        int bad;
        row_c = mk_row(7);
        row_d = mk_row(77);
        cfg_write(0, 24'h300);
        y_data[0] = row_c;
        pulse(4'b0001);
        cfg_write(0, 24'h400);
        y_data[0] = row_d;
        drain(1'b0, 4'b0001, 100);
        checks++; if (cap_addr[0] !== 24'h300) begin errors++; $display("FAIL clb_old_base got %h exp 300", cap_addr[0]); end
        checks++; if (cap_data[0] !== row_c[127:0]) begin errors++; $display("FAIL clb_old_data got %h exp %h", cap_data[0], row_c[127:0]); end
        checks++; if (wb_end !== 4'b0001) begin errors++; $display("FAIL clb_wb got %b exp 0001", wb_end); end
        checks++; if (overflow !== 4'b0010) begin errors++; $display("FAIL clb_overflow got %b exp 0010", overflow); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL clb_refilled got %b exp 1", busy); end
        drain(1'b0, 4'b0, 100);
        checks++; if (gap !== 1) begin errors++; $display("FAIL clb_gap got %0d exp 1", gap); end
        checks++; if (cap_addr[0] !== 24'h400) begin errors++; $display("FAIL clb_new_base got %h exp 400", cap_addr[0]); end
        checks++; if (cap_addr[10] !== 24'h40A) begin errors++; $display("FAIL clb_new_addr10 got %h exp 40a", cap_addr[10]); end
        bad = 0;
        for (int k = 0; k < NB; k++) if (cap_data[k] !== row_d[128*k +: 128]) bad++;
        checks++; if (bad !== 0) begin errors++; $display("FAIL clb_new_row got %0d bad exp 0", bad); end
        checks++; if (wb_end !== 4'b0001) begin errors++; $display("FAIL clb_new_wb got %b exp 0001", wb_end); end
    endtask

    task automatic test_reset_mid_row();
        int t, late;
        y_data[3] = mk_row(33);
        cfg_write(3, 24'h500);
        pulse(4'b1000);
        t = 0;
        while (!wr.wr_valid && t < 50) begin tick(); t++; end
        checks++; if (wr.wr_valid !== 1'b1) begin errors++; $display("FAIL rmr_start got %b exp 1", wr.wr_valid); end
        wr.wr_ready = 1'b1;
        repeat (5) tick();
        checks++; if (wr.wr_addr !== 24'h505) begin errors++; $display("FAIL rmr_beat5_addr got %h exp 505", wr.wr_addr); end
        rst = 1'b1;
        tick();
        wr.wr_ready = 1'b0;
        checks++; if (wr.wr_valid !== 1'b0) begin errors++; $display("FAIL rmr_valid got %b exp 0", wr.wr_valid); end
        checks++; if (wr.wr_addr !== 24'h0) begin errors++; $display("FAIL rmr_addr got %h exp 0", wr.wr_addr); end
        checks++; if (wr.wr_data !== 128'h0) begin errors++; $display("FAIL rmr_data got %h exp 0", wr.wr_data); end
        checks++; if (wb_done !== 4'b0) begin errors++; $display("FAIL rmr_wb_done got %b exp 0000", wb_done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmr_busy got %b exp 0", busy); end
        checks++; if (overflow !== 4'b0) begin errors++; $display("FAIL rmr_overflow got %b exp 0000", overflow); end
        rst = 1'b0;
        late = 0;
        repeat (20) begin
            tick();
            if (wr.wr_valid !== 1'b0 || wb_done !== 4'b0) late++;
        end
        checks++; if (late !== 0) begin errors++; $display("FAIL rmr_quiet got %0d active cycles exp 0", late); end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_row();
        test_backpressure();
        test_round_robin();
        test_overflow();
        test_capture_last_beat();
        test_reset_mid_row();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
